// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encoding
// (matches the decoder's funct3 field) and the control FSM states.
package mdu_pkg;

  // Operation encoding shared with the instruction decoder.
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [2:0] {
    MDU_MUL    = OP_MUL,
    MDU_MULH   = OP_MULH,
    MDU_MULHSU = OP_MULHSU,
    MDU_MULHU  = OP_MULHU,
    MDU_DIV    = OP_DIV,
    MDU_DIVU   = OP_DIVU,
    MDU_REM    = OP_REM,
    MDU_REMU   = OP_REMU
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  // Bit 2 of the encoding separates divide-class from multiply-class ops.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Within the divide class, bit 1 selects the remainder.
  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration on unsigned magnitudes. The partial
// remainder and the dividend/quotient register shift left together; the
// quotient bit enters at the bottom of quo_out.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Trial subtract; the partial remainder is always below the divisor, so
  // the top bit of the difference is a clean borrow flag.
  always_comb begin
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[XLEN]) begin
      rem_out = shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end else begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit (RV32M/RV64M style operations).
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready
// is high only in IDLE, out_valid only in DONE, and result/out_valid hold
// stable in DONE until taken. flush overrides everything and returns to IDLE.
// The first radix-2 step is executed on the accept edge from the input
// operands, so an iterative operation completes XLEN edges after (and
// including) the accept edge.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output mdu_state_e      dbg_state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e      state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] hi_q, lo_q, opb_q, res_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q, rem_neg_q;

  logic            accept;
  logic            is_div, a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;

  logic [XLEN-1:0] step_hi, step_lo, step_b;
  logic            step_div;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi_nx, mul_lo_nx, div_rem_nx, div_quo_nx;
  logic [XLEN-1:0] hi_nx, lo_nx, fin;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = out_valid ? res_q : '0;
  assign dbg_state = state;
  assign accept    = in_valid && in_ready;
  assign is_div    = op_is_div(op);

  // Operand signedness per operation (MUL's low half is sign-agnostic).
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  assign neg_a = a_signed & op1[XLEN-1];
  assign neg_b = b_signed & op2[XLEN-1];
  assign mag_a = neg_a ? -op1 : op1;
  assign mag_b = neg_b ? -op2 : op2;

  // Divide-by-zero and signed overflow complete on the accept edge.
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (is_div && (op2 == '0)) begin
      special     = 1'b1;
      special_res = op[1] ? op1 : '1;
    end else if (is_div && b_signed && (op1 == INT_MIN) && (&op2)) begin
      special     = 1'b1;
      special_res = op[1] ? '0 : op1;
    end
  end

  if (FAST_MUL) begin : g_fast
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN-1:0] fp;
    // Single-cycle product of sign/zero-extended operands.
    always_comb begin
      fa       = $signed({a_signed & op1[XLEN-1], op1});
      fb       = $signed({b_signed & op2[XLEN-1], op2});
      fp       = fa * fb;
      fast_res = (op == OP_MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
      fast_hit = !is_div;
    end
  end else begin : g_iter
    assign fast_res = '0;
    assign fast_hit = 1'b0;
  end

  // Step inputs come from the ports on the accept edge, else from registers.
  always_comb begin
    step_hi  = (state == IDLE) ? '0     : hi_q;
    step_lo  = (state == IDLE) ? mag_a  : lo_q;
    step_b   = (state == IDLE) ? mag_b  : opb_q;
    step_div = (state == IDLE) ? is_div : op_is_div(op_q);
  end

  // Shift-add multiply step: {hi,lo} shifts right, multiplier bits leave lo.
  always_comb begin
    mul_sum   = {1'b0, step_hi} + (step_lo[0] ? {1'b0, step_b} : '0);
    mul_hi_nx = mul_sum[XLEN:1];
    mul_lo_nx = {mul_sum[0], step_lo[XLEN-1:1]};
  end

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (step_hi),
    .quo_in  (step_lo),
    .divisor (step_b),
    .rem_out (div_rem_nx),
    .quo_out (div_quo_nx)
  );

  assign hi_nx = step_div ? div_rem_nx : mul_hi_nx;
  assign lo_nx = step_div ? div_quo_nx : mul_lo_nx;

  // Sign fix-up applied to the outputs of the final step.
  always_comb begin
    fin = '0;
    case (op_q)
      OP_MUL:                       fin = lo_nx;
      OP_MULH, OP_MULHSU, OP_MULHU: fin = neg_q ? (~hi_nx + XLEN'(lo_nx == '0)) : hi_nx;
      OP_DIV, OP_DIVU:              fin = neg_q ? -lo_nx : lo_nx;
      default:                      fin = rem_neg_q ? -hi_nx : hi_nx;
    endcase
  end

  // Control FSM and datapath registers; flush outranks every transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= op;
            neg_q     <= neg_a ^ neg_b;
            rem_neg_q <= neg_a;
            opb_q     <= mag_b;
            hi_q      <= hi_nx;
            lo_q      <= lo_nx;
            cnt_q     <= CW'(XLEN - 1);
            if (special) begin
              res_q <= special_res;
              state <= DONE;
            end else if (fast_hit) begin
              res_q <= fast_res;
              state <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          hi_q  <= hi_nx;
          lo_q  <= lo_nx;
          cnt_q <= cnt_q - 1'b1;
          // The counter reaches zero on this step: result is complete.
          if (cnt_q == CW'(1)) begin
            res_q <= fin;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: one iterative instance (FAST_MUL=0) and
// one single-cycle-multiply instance (FAST_MUL=1) sharing clock and reset.
module tb_mul_div_unit;
  import mdu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- iterative DUT ----------------
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [2:0]  op = 3'd0;
  logic [31:0] op1 = '0, op2 = '0, result;
  mdu_state_e  dbg_state;

  mul_div_unit #(.XLEN(32), .FAST_MUL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op1(op1), .op2(op2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- fast-multiply DUT ----------------
  logic        f_in_valid = 1'b0, f_flush = 1'b0, f_out_ready = 1'b0;
  logic        f_in_ready, f_out_valid, f_busy;
  logic [2:0]  f_op = 3'd0;
  logic [31:0] f_op1 = '0, f_op2 = '0, f_result;
  mdu_state_e  f_dbg_state;

  mul_div_unit #(.XLEN(32), .FAST_MUL(1'b1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .op(f_op), .op1(f_op1), .op2(f_op2), .flush(f_flush), .out_valid(f_out_valid),
    .out_ready(f_out_ready), .result(f_result), .busy(f_busy), .dbg_state(f_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1; op = o; op1 = a; op2 = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Latency counts the accept edge as edge 1.
  task automatic collect(input string tag, input int exp_lat);
    int lat;
    logic [31:0] e;
    lat = 1;
    @(negedge clk);
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result, e);
    check({tag, "_busy_rdy"}, in_ready, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_rdy_after"}, in_ready, 1'b1);
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] e, input int exp_lat);
    exp_q.push_back(e);
    issue(o, a, b);
    collect(tag, exp_lat);
  endtask

  task automatic fast_run(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e, input int exp_lat);
    int lat;
    @(negedge clk);
    f_in_valid = 1'b1; f_op = o; f_op1 = a; f_op2 = b;
    @(posedge clk);
    #1 f_in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (f_out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, f_result, e);
    f_out_ready = 1'b1;
    @(posedge clk);
    #1 f_out_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    logic seen;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_state", dbg_state, IDLE);
    check("rst_fast_ready", f_in_ready, 1'b1);
    rst_n = 1'b1;

    // Signed/unsigned divide and remainder
    run("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32);
    run("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32);
    run("div_7_m2",   OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
    run("rem_7_m2",   OP_REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         32);
    run("divu_100_7", OP_DIVU, 32'd100,       32'd7,         32'd14,        32);
    run("remu_100_7", OP_REMU, 32'd100,       32'd7,         32'd2,         32);
    run("divu_big",   OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32);
    run("remu_big",   OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32);

    // Divide by zero and signed overflow
    run("divu_by0",   OP_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, 1);
    run("remu_by0",   OP_REMU, 32'd100,       32'd0,         32'd100,       1);
    run("div_by0",    OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run("rem_by0",    OP_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1);
    run("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Iterative multiply
    run("mulh_m1",    OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32);
    run("mulhu_m1",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32);
    run("mulhsu_m1",  OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
    run("mul_m1",     OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32);
    run("mul_3_4",    OP_MUL,    32'd3,         32'd4,         32'd12,        32);
    run("mul_mix",    OP_MUL,    32'h1234_5678, 32'd9,         32'hA3D7_0A38, 32);
    run("mulh_min",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32);
    run("mulhsu_lo0", OP_MULHSU, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 32);

    // Single-cycle multiply instance
    fast_run("f_mulh_m1",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1);
    fast_run("f_mulhu_m1",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
    fast_run("f_mulhsu_m1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    fast_run("f_mul_3_4",   OP_MUL,    32'd3,         32'd4,         32'd12,        1);
    fast_run("f_div_m7_2",  OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32);

    // Flush five edges after a divide accept
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", busy, 1'b0);
    check("flush_rdy", in_ready, 1'b1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_valid", seen, 1'b0);
    run("mul_after_flush", OP_MUL, 32'd3, 32'd4, 32'd12, 32);

    // Result held while the consumer stalls
    issue(OP_DIVU, 32'd1000, 32'd3);
    lat = 1;
    @(negedge clk);
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("hold_lat", lat, 32);
    for (int i = 0; i < 10; i++) begin
      check("hold_res", result, 32'd333);
      check("hold_rdy", in_ready, 1'b0);
      check("hold_valid", out_valid, 1'b1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("hold_release", in_ready, 1'b1);

    // Asynchronous reset in the middle of a divide
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mid_busy", busy, 1'b1);
    check("mid_state", dbg_state, CALC);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_result", result, 32'h0);
    check("arst_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("arst_no_valid", seen, 1'b0);
    run("rem_after_rst", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width (legal 8..64, even).
REQ-002 SHALL have parameter FAST_MUL, default 0; 1 selects single-cycle multiply, 0 selects iterative multiply.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port op  input  3  operation, an mdu_op_e value (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-008 SHALL have ports op1 and op2  input  XLEN  rs1 and rs2 operands.
REQ-009 SHALL have port flush  input  1  abort any request in flight.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port result  output  XLEN  operation result.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and DONE.
REQ-015 SHALL drive in_ready high only in IDLE; an accept is in_valid && in_ready on a rising edge, and it latches op, op1 and op2.
REQ-016 On accept, SHALL go IDLE->CALC and load the step counter with XLEN-1.
REQ-017 On accept of a special case (REQ-021/022) or of a multiply with FAST_MUL=1, SHALL go IDLE->DONE.
REQ-018 In CALC, SHALL perform one radix-2 step per cycle (shift-add multiply, restoring divide) on magnitudes and decrement the counter; at counter==0, SHALL apply the sign fix-up and go CALC->DONE.
REQ-019 SHALL give latency, accept edge to out_valid high: XLEN edges for iterative operations; 1 edge for special cases and for fast multiply.
REQ-020 Results: MUL = low XLEN bits of the product; MULH/MULHSU/MULHU = high XLEN bits of the 2*XLEN product with signed x signed, signed x unsigned and unsigned x unsigned operands; DIV/DIVU round the quotient toward zero; the REM sign follows the dividend.
REQ-021 Divide by zero: quotient SHALL be all ones; remainder SHALL be op1.
REQ-022 Signed overflow (op1 = -2^(XLEN-1), op2 = -1): DIV SHALL return op1; REM SHALL return 0.
REQ-023 In DONE, out_valid and result SHALL hold stable until out_ready; on out_valid && out_ready, SHALL go DONE->IDLE.
REQ-024 SHALL NOT accept a new request in the cycle that a result is taken; in_ready rises one cycle later.
REQ-025 flush SHALL force IDLE on the next edge from any state and takes priority over accept, completion and out_ready; the aborted result is never presented.
REQ-026 result SHALL be 0 whenever out_valid is low.

Reset
REQ-027 While rst_n is low, SHALL hold state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, and all counters and datapath registers at 0.
REQ-028 Reset asserted mid-operation SHALL discard the request with no output; the first accept becomes possible on the first edge after deassertion.

Structure
REQ-029 Package mdu_pkg SHALL hold mdu_op_e, the mdu_state_e FSM enum and the op encoding constants shared with the decoder.
REQ-030 One sub-module, mdu_div_step (combinational, one restoring-divide iteration, XLEN-parametrised), SHALL be instantiated once inside mul_div_unit.
REQ-031 Implementation SHALL be 120-400 RTL lines with no multicycle paths; the FAST_MUL=1 multiplier is the only wide combinational product.

Verification
REQ-032 DIV with op1=-7, op2=2, XLEN=32: result=0xFFFFFFFD (-3), out_valid exactly 32 edges after accept; REM of the same operands gives 0xFFFFFFFF.
REQ-033 DIVU with op1=100, op2=0: result=0xFFFFFFFF after 1 edge; REMU of the same operands gives 100.
REQ-034 DIV with op1=0x80000000, op2=0xFFFFFFFF: result=0x80000000; REM of the same operands gives 0, both after 1 edge.
REQ-035 MULH with op1=0xFFFFFFFF, op2=0xFFFFFFFF: result=0; MULHU of the same operands gives 0xFFFFFFFE; MULHSU of the same operands gives 0xFFFFFFFF; run with FAST_MUL=0 and FAST_MUL=1.
REQ-036 flush 5 cycles after a DIV accept: busy=0 and in_ready=1 next cycle, out_valid never rises; the following MUL with op1=3, op2=4 returns 12.
REQ-037 out_ready held low for 10 cycles in DONE: result stable, in_ready low; rst_n pulsed low mid-CALC: all outputs at reset values immediately.
